// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - RSA modular exponentiation engine (out = in^k mod n)
// Left-to-right square-and-multiply over a bit-serial interleaved modular multiplier.
module rsa_modexp_engine #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_mode,
  input  logic [EXP_WIDTH-1:0] key_e,
  input  logic [EXP_WIDTH-1:0] key_d,
  input  logic [WIDTH-1:0]     key_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     n_q;
  logic [EXP_WIDTH-1:0] k_q;
  logic [IW-1:0]        idx_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     r_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     base_q;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_err_q;

  logic [WIDTH:0]       dbl;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     r_half;
  logic [WIDTH-1:0]     r_d;
  logic                 mm_last;

  // One multiplier step. R and b stay below n, so each reduced value fits in
  // WIDTH bits and the WIDTH-bit wrap-around subtraction yields the exact result.
  always_comb begin
    dbl     = {r_q, 1'b0};
    r_half  = dbl[WIDTH-1:0];
    r_d     = '0;
    if (dbl >= {1'b0, n_q}) begin
      r_half = dbl[WIDTH-1:0] - n_q;
    end
    sum = {1'b0, r_half} + {1'b0, b_q};
    if (!a_q[WIDTH-1]) begin
      r_d = r_half;
    end else if (sum >= {1'b0, n_q}) begin
      r_d = sum[WIDTH-1:0] - n_q;
    end else begin
      r_d = sum[WIDTH-1:0];
    end
    mm_last = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            n_q <= key_n;
            k_q <= in_mode ? key_d : key_e;
            if (key_n < WIDTH'(2)) begin
              out_data_q <= '0;
              out_err_q  <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              a_q     <= in_data;
              b_q     <= WIDTH'(1);
              r_q     <= '0;
              cnt_q   <= '0;
              idx_q   <= IW'(EXP_WIDTH - 1);
              state_q <= S_REDUCE;
            end
          end
        end

        S_REDUCE, S_SQR, S_MUL: begin
          if (!mm_last) begin
            r_q   <= r_d;
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
          end else begin
            r_q   <= '0;
            cnt_q <= '0;
            case (state_q)
              S_REDUCE: begin
                // The accumulator starts at 1, so the first square is 1*1.
                base_q  <= r_d;
                a_q     <= WIDTH'(1);
                b_q     <= WIDTH'(1);
                state_q <= S_SQR;
              end
              S_SQR: begin
                if (k_q[idx_q]) begin
                  a_q     <= r_d;
                  b_q     <= base_q;
                  state_q <= S_MUL;
                end else if (idx_q == '0) begin
                  out_data_q <= r_d;
                  out_err_q  <= 1'b0;
                  state_q    <= S_DONE;
                end else begin
                  idx_q <= idx_q - IW'(1);
                  a_q   <= r_d;
                  b_q   <= r_d;
                end
              end
              default: begin
                if (idx_q == '0) begin
                  out_data_q <= r_d;
                  out_err_q  <= 1'b0;
                  state_q    <= S_DONE;
                end else begin
                  idx_q   <= idx_q - IW'(1);
                  a_q     <= r_d;
                  b_q     <= r_d;
                  state_q <= S_SQR;
                end
              end
            endcase
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb/tb_rsa_modexp_engine.sv - self-checking bench for rsa_modexp_engine
// Vector table plus randomized vectors scored against an arithmetic model.
module tb_rsa_modexp_engine;

  localparam int W  = 32;
  localparam int EW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic [EW-1:0] key_e;
  logic [EW-1:0] key_d;
  logic [W-1:0]  key_n;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .key_e     (key_e),
    .key_d     (key_d),
    .key_n     (key_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        mode;
    logic [31:0] e;
    logic [31:0] d;
    logic [31:0] n;
    logic [31:0] exp_out;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  // Right-to-left binary exponentiation on 64-bit integers.
  function automatic logic [31:0] ref_modexp(logic [31:0] x, logic [31:0] k, logic [31:0] n);
    logic [63:0] res, p, nn;
    if (n < 2) return 32'd0;
    nn  = {32'd0, n};
    res = 64'd1;
    p   = {32'd0, x} % nn;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) res = (res * p) % nn;
      p = (p * p) % nn;
    end
    return res[31:0];
  endfunction

  function automatic int ref_latency(logic [31:0] k, logic [31:0] n);
    if (n < 2) return 1;
    return (1 + EW + $countones(k)) * W;
  endfunction

  function automatic vec_t mk(logic [31:0] data, logic mode, logic [31:0] e, logic [31:0] d,
                              logic [31:0] n, logic [31:0] exp_out, logic exp_err, int exp_lat);
    vec_t v;
    v.data = data; v.mode = mode; v.e = e; v.d = d; v.n = n;
    v.exp_out = exp_out; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  function automatic vec_t mk_rand();
    vec_t v;
    logic [31:0] k;
    v.data = $urandom;
    v.mode = 1'($urandom_range(0, 1));
    v.e    = $urandom;
    v.d    = $urandom;
    v.n    = $urandom;
    if (v.n < 2) v.n = 32'd2;
    k = v.mode ? v.d : v.e;
    v.exp_out = ref_modexp(v.data, k, v.n);
    v.exp_err = 1'b0;
    v.exp_lat = ref_latency(k, v.n);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Enters at a negedge with the engine idle; leaves at the negedge after accept.
  task automatic start(input vec_t v, input string tag);
    check({tag, " in_ready_before_accept"}, in_ready, 1);
    in_data  = v.data;
    in_mode  = v.mode;
    key_e    = v.e;
    key_d    = v.d;
    key_n    = v.n;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    key_n    = $urandom;
    key_e    = $urandom;
    key_d    = $urandom;
    in_mode  = ~in_mode;
  endtask

  task automatic wait_result(input vec_t v, input string tag);
    int cyc = 0;
    bit hs_ok = 1'b1;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      if (!out_valid && (in_ready || !busy)) hs_ok = 1'b0;
      if (!out_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        key_n    = $urandom;
      end
    end while (!out_valid && cyc < 4000);
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, cyc, v.exp_lat);
    check({tag, " out_data"}, out_data, v.exp_out);
    check({tag, " out_err"}, out_err, v.exp_err);
    check({tag, " busy_while_computing"}, hs_ok, 1);
    check({tag, " in_ready_low_in_done"}, in_ready, 0);
  endtask

  task automatic handoff(input vec_t v, input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " out_valid_after_handoff"}, out_valid, 0);
    check({tag, " in_ready_after_handoff"}, in_ready, 1);
    check({tag, " out_data_kept"}, out_data, v.exp_out);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t  enc;
    bit    held_ok;
    string tag;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_mode = 1'b0; key_e = '0; key_d = '0; key_n = '0;

    vecs.push_back(mk(32'd65,   1'b0, 32'd17, 32'd2753, 32'd3233, 32'd2790, 1'b0, 1120));
    vecs.push_back(mk(32'd2790, 1'b1, 32'd17, 32'd2753, 32'd3233, 32'd65,   1'b0, 1216));
    vecs.push_back(mk(32'd3298, 1'b0, 32'd17, 32'd2753, 32'd3233, 32'd2790, 1'b0, 1120));
    vecs.push_back(mk(32'd123,  1'b0, 32'd0,  32'd2753, 32'd3233, 32'd1,    1'b0, 1056));
    vecs.push_back(mk(32'd5,    1'b0, 32'd17, 32'd2753, 32'd1,    32'd0,    1'b1, 1));
    vecs.push_back(mk(32'd77,   1'b1, 32'd17, 32'd2753, 32'd0,    32'd0,    1'b1, 1));
    vecs.push_back(mk(32'd7,    1'b0, 32'd5,  32'd9,    32'd2,    32'd1,    1'b0, 1120));
    vecs.push_back(mk(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 2080));
    vecs.push_back(mk(32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 2080));
    for (int i = 0; i < 6; i++) vecs.push_back(mk_rand());
    enc = vecs[0];

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_err", out_err, 0);
    check("reset busy", busy, 0);
    @(negedge clk);

    // Back-to-back: each request is driven in the negedge right after hand-off.
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      start(vecs[i], tag);
      wait_result(vecs[i], tag);
      handoff(vecs[i], tag);
    end

    start(enc, "bp");
    wait_result(enc, "bp");
    held_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'(i % 2);
      in_data  = $urandom;
      key_n    = $urandom;
      @(posedge clk);
      #1;
      if (!out_valid || out_data !== 32'd2790 || out_err || in_ready) held_ok = 1'b0;
    end
    check("bp result_held", held_ok, 1);
    handoff(enc, "bp");

    start(enc, "rst");
    repeat (W + 5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    held_ok = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid || busy || !in_ready) held_ok = 1'b0;
    end
    check("rst discarded", held_ok, 1);
    @(negedge clk);
    start(enc, "after_rst");
    wait_result(enc, "after_rst");
    handoff(enc, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
